// File: rtl/pulse_measure_pkg.sv
// Shared types and helpers for the pulse_measure block.
package pulse_measure_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StHigh  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // All-ones value of a counter of the given width (1..32).
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load and an at-maximum flag.
module sat_counter
  import pulse_measure_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [Width-1:0] MaxVal = Width'(sat_max(Width));

  logic [Width-1:0] count_q, count_d;

  assign at_max_o = (count_q == MaxVal);
  assign count_o  = count_q;

  // Load wins over increment.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && !at_max_o) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pulse_measure.sv
// Measures enable-to-pulse delay and pulse width, one result per enable assertion.
// Optional armed-state timeout is compiled in with PULSE_MEASURE_TIMEOUT_EN.
module pulse_measure
  import pulse_measure_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pulse,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] delay_out,
  output logic [CNT_W-1:0] width_out,
  output logic             ovf,
  output logic             timeout
);

  if (CNT_W < 2 || CNT_W > 32 || TIMEOUT == 0) begin : g_bad_params
    $error("pulse_measure: CNT_W must be 2..32 and TIMEOUT nonzero");
  end

  state_e           state_q;
  logic             dly_load, dly_inc, wid_load, wid_inc;
  logic [CNT_W-1:0] dly_cnt, wid_cnt;
  logic             dly_max, wid_max;
  logic             to_hit;

`ifdef PULSE_MEASURE_TIMEOUT_EN
  // True on the armed edge that would bring the delay count up to TIMEOUT.
  assign to_hit = !dly_max && ((33'(dly_cnt) + 33'd1) == 33'(TIMEOUT));

  logic timeout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == StArmed) && enable && !pulse && to_hit;
    end
  end
  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    dly_load = 1'b0;
    dly_inc  = 1'b0;
    wid_load = 1'b0;
    wid_inc  = 1'b0;
    unique case (state_q)
      StIdle:  dly_load = enable && !pulse;
      StArmed: begin
        dly_inc  = enable && !pulse;
        wid_load = enable && pulse;
      end
      StHigh:  wid_inc = pulse;
      default: ;
    endcase
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_delay_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (dly_load),
    .load_val_i ('0),
    .inc_i      (dly_inc),
    .count_o    (dly_cnt),
    .at_max_o   (dly_max)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_width_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (wid_load),
    .load_val_i (CNT_W'(1)),
    .inc_i      (wid_inc),
    .count_o    (wid_cnt),
    .at_max_o   (wid_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      delay_out  <= '0;
      width_out  <= '0;
      ovf        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable && !pulse) begin
            state_q <= StArmed;
            busy    <= 1'b1;
          end
        end
        StArmed: begin
          if (!enable) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (pulse) begin
            state_q <= StHigh;
          end else if (to_hit) begin
            state_q <= StDone;
            busy    <= 1'b0;
          end
        end
        StHigh: begin
          if (!pulse) begin
            state_q    <= StDone;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            delay_out  <= dly_cnt;
            width_out  <= wid_cnt;
            ovf        <= dly_max || wid_max;
          end
        end
        StDone: begin
          // Hold here until enable drops so each assertion yields one result.
          if (!enable) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Randomized self-checking bench: an 8-bit and a 4-bit instance share stimulus.
module tb_pulse_measure;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic pulse;

  logic       busy8, mv8, ovf8, to8;
  logic [7:0] dly8, wid8;
  logic       busy4, mv4, ovf4, to4;
  logic [3:0] dly4, wid4;

  logic        bz[2], mv[2], ov[2], tq[2];
  logic [31:0] dly[2], wid[2];

  int n_checks = 0;
  int n_errors = 0;
  int vcnt[2];
  int tcnt[2];

  int exp_dly[2];
  int exp_wid[2];
  bit exp_ovf[2];

`ifdef PULSE_MEASURE_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  always #5 clk = ~clk;

  pulse_measure #(
    .CNT_W   (8),
    .TIMEOUT (20)
  ) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pulse      (pulse),
    .busy       (busy8),
    .meas_valid (mv8),
    .delay_out  (dly8),
    .width_out  (wid8),
    .ovf        (ovf8),
    .timeout    (to8)
  );

  pulse_measure #(
    .CNT_W   (4),
    .TIMEOUT (12)
  ) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pulse      (pulse),
    .busy       (busy4),
    .meas_valid (mv4),
    .delay_out  (dly4),
    .width_out  (wid4),
    .ovf        (ovf4),
    .timeout    (to4)
  );

  assign bz[0]  = busy8;
  assign bz[1]  = busy4;
  assign mv[0]  = mv8;
  assign mv[1]  = mv4;
  assign ov[0]  = ovf8;
  assign ov[1]  = ovf4;
  assign tq[0]  = to8;
  assign tq[1]  = to4;
  assign dly[0] = 32'(dly8);
  assign dly[1] = 32'(dly4);
  assign wid[0] = 32'(wid8);
  assign wid[1] = 32'(wid4);

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (mv[d]) vcnt[d]++;
        if (tq[d]) tcnt[d]++;
      end
    end
  end

  function automatic int max_of(input int d);
    return (d == 0) ? 255 : 15;
  endfunction

  function automatic int limit_of(input int d);
    return (d == 0) ? 20 : 12;
  endfunction

  function automatic int clip(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_dly%0d", tag, d), dly[d], 32'(exp_dly[d]));
      check($sformatf("%s_wid%0d", tag, d), wid[d], 32'(exp_wid[d]));
      check($sformatf("%s_ovf%0d", tag, d), 32'(ov[d]), 32'(exp_ovf[d]));
    end
  endtask

  // Arm, n low armed edges, w high edges, falling edge, extra cycles, then drop enable.
  task automatic run_meas(input int n, input int w, input int extra, input string tag);
    int v0[2];
    int t0[2];
    bit hit[2];
    for (int d = 0; d < 2; d++) begin
      v0[d]  = vcnt[d];
      t0[d]  = tcnt[d];
      hit[d] = TimeoutOn && (n >= limit_of(d));
      if (!hit[d]) begin
        exp_dly[d] = clip(n, max_of(d));
        exp_wid[d] = clip(w, max_of(d));
        exp_ovf[d] = (n >= max_of(d)) || (w >= max_of(d));
      end
    end
    enable = 1'b1;
    pulse  = 1'b0;
    step();
    repeat (n) step();
    pulse = 1'b1;
    repeat (w) step();
    for (int d = 0; d < 2; d++) check($sformatf("%s_busy_high%0d", tag, d), 32'(bz[d]), 32'(!hit[d]));
    pulse = 1'b0;
    step();
    for (int d = 0; d < 2; d++) check($sformatf("%s_strobe%0d", tag, d), 32'(mv[d]), 32'(!hit[d]));
    repeat (extra) step();
    enable = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_nvalid%0d", tag, d), 32'(vcnt[d] - v0[d]), 32'(!hit[d]));
      check($sformatf("%s_ntimeout%0d", tag, d), 32'(tcnt[d] - t0[d]), 32'(hit[d]));
      check($sformatf("%s_busy_end%0d", tag, d), 32'(bz[d]), 32'd0);
    end
    check_held(tag);
  endtask

  initial begin
    int v0[2];
    int t0[2];
    vcnt    = '{0, 0};
    tcnt    = '{0, 0};
    exp_dly = '{0, 0};
    exp_wid = '{0, 0};
    exp_ovf = '{1'b0, 1'b0};
    rst_n   = 1'b0;
    enable  = 1'b0;
    pulse   = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d), 32'(bz[d]), 32'd0);
      check($sformatf("rst_mv%0d", d), 32'(mv[d]), 32'd0);
      check($sformatf("rst_to%0d", d), 32'(tq[d]), 32'd0);
    end
    check_held("rst");
    rst_n = 1'b1;
    step();

    // Basic measurement, then a held enable yields only one result, then a re-arm.
    run_meas(5, 2, 30, "basic");
    run_meas(5, 2, 0, "rearm");

    // Pulse already high when enable rises: stays idle.
    enable = 1'b1;
    pulse  = 1'b1;
    repeat (3) step();
    for (int d = 0; d < 2; d++) check($sformatf("nobusy_hi%0d", d), 32'(bz[d]), 32'd0);
    enable = 1'b0;
    pulse  = 1'b0;
    step();

    // Abort on the third armed edge.
    for (int d = 0; d < 2; d++) v0[d] = vcnt[d];
    enable = 1'b1;
    step();
    repeat (2) step();
    for (int d = 0; d < 2; d++) check($sformatf("abort_busy_pre%0d", d), 32'(bz[d]), 32'd1);
    enable = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_busy%0d", d), 32'(bz[d]), 32'd0);
      check($sformatf("abort_nvalid%0d", d), 32'(vcnt[d] - v0[d]), 32'd0);
    end
    check_held("abort");

    // Width saturation on the narrow instance.
    run_meas(3, 20, 0, "wsat");

`ifdef PULSE_MEASURE_TIMEOUT_EN
    for (int d = 0; d < 2; d++) t0[d] = tcnt[d];
    enable = 1'b1;
    pulse  = 1'b0;
    step();
    repeat (19) step();
    check("to_early", 32'(to8), 32'd0);
    step();
    check("to_strobe", 32'(to8), 32'd1);
    check("to_mv", 32'(mv8), 32'd0);
    check("to_busy", 32'(busy8), 32'd0);
    repeat (3) step();
    enable = 1'b0;
    step();
    check("to_n8", 32'(tcnt[0] - t0[0]), 32'd1);
    check("to_n4", 32'(tcnt[1] - t0[1]), 32'd1);
    check_held("to");
`else
    // Without the timeout, arming waits indefinitely.
    for (int d = 0; d < 2; d++) t0[d] = tcnt[d];
    enable = 1'b1;
    pulse  = 1'b0;
    step();
    repeat (300) step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("wait_busy%0d", d), 32'(bz[d]), 32'd1);
      check($sformatf("wait_nto%0d", d), 32'(tcnt[d] - t0[d]), 32'd0);
    end
    enable = 1'b0;
    step();
`endif

    for (int i = 0; i < 16; i++) begin
      run_meas(int'($urandom_range(0, 24)), int'($urandom_range(1, 20)),
               int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    // Reset asserted while the pulse is high discards the measurement.
    for (int d = 0; d < 2; d++) v0[d] = vcnt[d];
    enable = 1'b1;
    pulse  = 1'b0;
    step();
    repeat (2) step();
    pulse = 1'b1;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    exp_dly = '{0, 0};
    exp_wid = '{0, 0};
    exp_ovf = '{1'b0, 1'b0};
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_busy%0d", d), 32'(bz[d]), 32'd0);
      check($sformatf("midrst_mv%0d", d), 32'(mv[d]), 32'd0);
      check($sformatf("midrst_to%0d", d), 32'(tq[d]), 32'd0);
    end
    check_held("midrst");
    step();
    rst_n = 1'b1;
    repeat (3) step();
    for (int d = 0; d < 2; d++) check($sformatf("postrst_busy%0d", d), 32'(bz[d]), 32'd0);
    enable = 1'b0;
    pulse  = 1'b0;
    repeat (2) step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("postrst_nvalid%0d", d), 32'(vcnt[d] - v0[d]), 32'd0);
    end
    check_held("postrst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_measure.md
PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001: Parameter CNT_W, default 8, SHALL set the width in bits of the delay and width result counters; legal range 2..32.
REQ-002: Parameter TIMEOUT, default 200, SHALL set the maximum armed cycles before abandoning a measurement; it is used only when PULSE_MEASURE_TIMEOUT_EN is defined.
REQ-003: clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004: rst_n  input  1  SHALL be the reset; it is asynchronous and active-low.
REQ-005: enable  input  1  SHALL arm a measurement while high.
REQ-006: pulse  input  1  SHALL be the pulse under measurement; it is synchronous to clk.
REQ-007: busy  output  1  SHALL be high in the ARMED and HIGH states.
REQ-008: meas_valid  output  1  SHALL be a one-cycle strobe that marks a completed measurement.
REQ-009: delay_out  output  CNT_W  SHALL hold the last measured delay in cycles.
REQ-010: width_out  output  CNT_W  SHALL hold the last measured pulse width in cycles.
REQ-011: ovf  output  1  SHALL be high when either counter saturated in the last measurement.
REQ-012: timeout  output  1  SHALL be a one-cycle strobe on timeout; it is tied 0 when the timeout feature is compiled out.

Function
REQ-013: The FSM SHALL have exactly four states: IDLE, ARMED, HIGH and DONE.
REQ-014: IDLE SHALL go to ARMED on an edge sampling enable=1 and pulse=0, clearing the delay counter; with enable=1 and pulse=1 it SHALL stay in IDLE.
REQ-015: In ARMED, each edge sampling pulse=0 SHALL increment the delay counter, saturating at 2^CNT_W-1.
REQ-016: In ARMED, the first edge sampling pulse=1 SHALL go to HIGH and load the width counter with 1.
REQ-017: Delay semantics: the delay SHALL equal the number of ARMED edges that sampled pulse=0; a generator with wait N driven by the same enable SHALL yield delay N.
REQ-018: In ARMED, an edge sampling enable=0 SHALL abort to IDLE with no meas_valid, and the held outputs SHALL stay unchanged.
REQ-019: In HIGH, each edge sampling pulse=1 SHALL increment the width counter, saturating at 2^CNT_W-1; enable is ignored in HIGH.
REQ-020: In HIGH, the edge sampling pulse=0 SHALL go to DONE and register delay_out, width_out and ovf, with meas_valid=1 for exactly that cycle.
REQ-021: Measured results SHALL therefore be visible one cycle after the falling edge of pulse is sampled.
REQ-022: DONE SHALL go to IDLE on an edge sampling enable=0; while enable stays high, no further measurement SHALL occur, giving one measurement per enable assertion.
REQ-023: ovf SHALL be set if either counter was saturated at capture time.
REQ-024: delay_out, width_out and ovf SHALL hold their values until the next meas_valid or reset.

Reset
REQ-025: When rst_n=0, the block SHALL asynchronously force state IDLE and set busy, meas_valid, delay_out, width_out, ovf, timeout and both counters to 0.
REQ-026: Reset asserted mid-measurement SHALL discard the measurement without producing a strobe.
REQ-027: After rst_n deasserts, the block SHALL require a fresh enable=1 with pulse=0 before arming.

Configuration
REQ-028: With macro PULSE_MEASURE_TIMEOUT_EN defined, the ARMED edge on which the delay counter reaches TIMEOUT with pulse=0 SHALL go to DONE, assert timeout for one cycle and produce no meas_valid.
REQ-029: Without PULSE_MEASURE_TIMEOUT_EN, timeout SHALL be constant 0 and ARMED SHALL wait indefinitely, with the delay counter saturating.

Structure
REQ-030: Package pulse_measure_pkg SHALL hold the FSM state typedef (2-bit encoding) and the saturation-max helper constant function.
REQ-031: The counter SHALL be a single sub-module, sat_counter: a parameterised width counter with load, increment, saturation and an at_max flag, instantiated twice.

Verification
REQ-032: N=5, PULSE_WIDTH=2 generator output driven into pulse, with enable shared -> meas_valid once, delay_out=5, width_out=2, ovf=0.
REQ-033: enable held high for 30 cycles after the first measurement -> exactly one meas_valid in total; after enable is low for 1 cycle and re-raised -> a second identical result.
REQ-034: enable dropped at ARMED edge 3 -> no meas_valid, busy=0 on the next cycle, outputs unchanged.
REQ-035: CNT_W=4, pulse high for 20 cycles -> width_out=15, ovf=1.
REQ-036: Build with PULSE_MEASURE_TIMEOUT_EN, TIMEOUT=20, pulse held 0 -> timeout strobe after the 20th ARMED edge, no meas_valid, state DONE.
REQ-037: rst_n pulsed low during HIGH -> all outputs 0 immediately, no strobe after release.
